// File: rtl/mbist_march_ctrl.sv
// March C- MBIST sequencer for a single-port memory with a RD_LATENCY-deep
// read-compare pipeline. Reports pass/fail, first failing address and a
// saturating mismatch count.
module mbist_march_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_WORDS  = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [7:0]            fail_count,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_DRAIN, S_DONE} state_t;
  typedef enum logic [2:0] {E_M0, E_M1, E_M2, E_M3, E_M4, E_M5} elem_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);
  localparam int DCW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(RD_LATENCY - 1);

  state_t                state, state_d;
  elem_t                 elem, elem_d, elem_nxt;
  logic                  op_sel, op_sel_d;
  logic [ADDR_WIDTH-1:0] addr, addr_d;
  logic [DATA_WIDTH-1:0] wdata, wdata_d, wdata_nxt;
  logic [DCW-1:0]        drain, drain_d;
  logic                  start_acc;

  logic                  elem_down, elem_two_ops, exp_ones, nxt_down;
  logic                  op_is_write, last_op, last_addr, rd_push;
  logic [DATA_WIDTH-1:0] rd_exp;

  logic                  pv [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] pa [RD_LATENCY];
  logic [DATA_WIDTH-1:0] pe [RD_LATENCY];
  logic                  mismatch;

  // Decode of the current element and the current RUN operation
  always_comb begin
    elem_down    = (elem == E_M3) || (elem == E_M4) || (elem == E_M5);
    elem_two_ops = (elem != E_M0) && (elem != E_M5);
    exp_ones     = (elem == E_M2) || (elem == E_M4);
    op_is_write  = (elem == E_M0) || op_sel;
    last_op      = !elem_two_ops || op_sel;
    last_addr    = elem_down ? (addr == '0) : (addr == LAST_ADDR);
    rd_push      = (state == S_RUN) && !op_is_write;
    rd_exp       = exp_ones ? '1 : '0;
    elem_nxt     = elem_t'(elem + 3'd1);
    nxt_down     = (elem_nxt == E_M3) || (elem_nxt == E_M4) || (elem_nxt == E_M5);
    wdata_nxt    = wdata;
    case (elem_nxt)
      E_M1, E_M3:       wdata_nxt = '1;
      E_M0, E_M2, E_M4: wdata_nxt = '0;
      default:          wdata_nxt = wdata;
    endcase
  end

  // Next-state and sequencing counters
  always_comb begin
    state_d   = state;
    elem_d    = elem;
    op_sel_d  = op_sel;
    addr_d    = addr;
    wdata_d   = wdata;
    drain_d   = drain;
    start_acc = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          start_acc = 1'b1;
          state_d   = S_SETUP;
          elem_d    = E_M0;
          op_sel_d  = 1'b0;
          addr_d    = '0;
          wdata_d   = '0;
        end
      end
      S_SETUP: begin
        state_d  = S_RUN;
        op_sel_d = 1'b0;
      end
      S_RUN: begin
        if (!last_op) begin
          op_sel_d = 1'b1;
        end else begin
          op_sel_d = 1'b0;
          if (!last_addr) begin
            addr_d = elem_down ? addr - 1'b1 : addr + 1'b1;
          end else if (elem == E_M5) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end else begin
            state_d = S_SETUP;
            elem_d  = elem_nxt;
            addr_d  = nxt_down ? LAST_ADDR : '0;
            wdata_d = wdata_nxt;
          end
        end
      end
      S_DRAIN: begin
        if (drain == DRAIN_LAST) state_d = S_DONE;
        else                     drain_d = drain + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and sequencing registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      elem   <= E_M0;
      op_sel <= 1'b0;
      addr   <= '0;
      wdata  <= '0;
      drain  <= '0;
    end else begin
      state  <= state_d;
      elem   <= elem_d;
      op_sel <= op_sel_d;
      addr   <= addr_d;
      wdata  <= wdata_d;
      drain  <= drain_d;
    end
  end

  // Read-compare pipeline: tracks {valid, address, expected} per issued read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= '0;
        pe[i] <= '0;
      end
    end else begin
      pv[0] <= rd_push;
      pa[0] <= addr;
      pe[0] <= rd_exp;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
        pe[i] <= pe[i-1];
      end
    end
  end

  assign mismatch = pv[RD_LATENCY-1] && (mem_rdata != pe[RD_LATENCY-1]);

  // Fail status: cleared on start acceptance, updated on each mismatch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_count <= '0;
    end else if (start_acc) begin
      fail       <= 1'b0;
      fail_addr  <= '0;
      fail_count <= '0;
    end else if (mismatch) begin
      fail <= 1'b1;
      if (!fail) fail_addr <= pa[RD_LATENCY-1];
      if (fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
    end
  end

  assign busy           = (state == S_SETUP) || (state == S_RUN) || (state == S_DRAIN);
  assign done           = (state == S_DONE);
  assign mem_write_read = (state == S_RUN) && op_is_write;
  assign mem_address    = addr;
  assign mem_wdata      = wdata;

endmodule
